// File: rtl/ecc_145_enc_fault_detc.sv
// SECDED write-side encoder, dual-encoder self-check, test error injector.
// Latency: 1 cycle from acceptance to out_valid; one beat per cycle.
// Backpressure: one-deep output register, in_ready = ~out_valid | out_ready.

module ecc_145_enc_parity #(
   parameter int DATA_WIDTH   = 145,
   parameter int PARITY_WIDTH = 9
) (
   input  logic [DATA_WIDTH-1:0]   data,
   output logic [PARITY_WIDTH-1:0] parity
);

   // Data bit k sits at the k-th non-power-of-two codeword position (3,5,6,7,9,...).
   // Hamming bit i covers every data bit whose position has bit i set.
   function automatic logic [DATA_WIDTH-1:0] mask_of(input int bit_i);
      logic [DATA_WIDTH-1:0] m;
      int k;
      m = '0;
      k = 0;
      for (int pos = 3; pos < (1 << (PARITY_WIDTH - 1)); pos++) begin
         if (k < DATA_WIDTH && (pos & (pos - 1)) != 0) begin
            if (((pos >> bit_i) & 1) != 0) m[k] = 1'b1;
            k++;
         end
      end
      return m;
   endfunction

   logic [PARITY_WIDTH-2:0] ham;

   for (genvar i = 0; i < PARITY_WIDTH - 1; i++) begin : g_ham
      localparam logic [DATA_WIDTH-1:0] MASK = mask_of(i);
      assign ham[i] = ^(data & MASK);
   end

   // Overall parity covers data and Hamming bits so double errors are detectable.
   assign parity = {(^data) ^ (^ham), ham};

endmodule

module ecc_145_enc_fault_detc #(
   parameter int DATA_WIDTH      = 145,
   parameter int PARITY_WIDTH    = 9,
   parameter int FAULT_CNT_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ecc_fault_detc_en,
   input  logic                       bypass,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_WIDTH-1:0]      data_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_WIDTH-1:0]      data_out,
   output logic [PARITY_WIDTH-1:0]    parity_out,
   output logic                       ecc_fault,
   output logic                       ecc_fault_sticky,
   output logic [FAULT_CNT_WIDTH-1:0] fault_cnt,
   input  logic                       fault_clr,
   input  logic                       chk_inj,
   input  logic                       inj_req,
   input  logic                       inj_dbl,
   input  logic [7:0]                 inj_pos
);

   localparam int unsigned DW_U = DATA_WIDTH;

   typedef enum logic {IDLE, ARMED} inj_state_t;

   inj_state_t                state, state_nxt;
   logic                      accept;
   logic [PARITY_WIDTH-1:0]   enc0_par, enc1_par, par0, par1, par1_chk;
   logic                      fault_now;
   logic                      fault_q;
   logic                      dbl_q;
   logic [7:0]                pos_q, pos_mod, pos2;
   logic [DATA_WIDTH-1:0]     flip;

   assign in_ready = ~out_valid | out_ready;
   assign accept   = in_valid & in_ready;

   // Two identical encoders; the second only feeds the compare.
   ecc_145_enc_parity #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_enc0 (
      .data   (data_in),
      .parity (enc0_par)
   );
   ecc_145_enc_parity #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_enc1 (
      .data   (data_in),
      .parity (enc1_par)
   );

   assign par0      = bypass ? '0 : enc0_par;
   assign par1      = bypass ? '0 : enc1_par;
   assign par1_chk  = {par1[PARITY_WIDTH-1:1], par1[0] ^ chk_inj};
   assign fault_now = (|(par0 ^ par1_chk)) & ecc_fault_detc_en;
   assign ecc_fault = out_valid & fault_q;

   assign pos_mod = 8'(32'(inj_pos) % DW_U);
   assign pos2    = (pos_q == 8'(DATA_WIDTH - 1)) ? 8'd0 : pos_q + 8'd1;

   // Injector state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Injector next state and flip mask; an armed injection hits the next accepted beat.
   always_comb begin
      state_nxt = state;
      flip      = '0;
      case (state)
         IDLE: begin
            if (inj_req) state_nxt = ARMED;
         end
         ARMED: begin
            if (accept) begin
               flip[pos_q] = 1'b1;
               if (dbl_q) flip[pos2] = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Capture injection type and position only when arming from IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbl_q <= 1'b0;
         pos_q <= '0;
      end else if (state == IDLE && inj_req) begin
         dbl_q <= inj_dbl;
         pos_q <= pos_mod;
      end
   end

   // Output stage: parity is from clean data, flips land only on the stored data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         data_out   <= '0;
         parity_out <= '0;
         fault_q    <= 1'b0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         data_out   <= data_in ^ flip;
         parity_out <= par0;
         fault_q    <= fault_now;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

   // Saturating fault counter and sticky flag; a clear coinciding with a fault leaves one count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault_cnt        <= '0;
         ecc_fault_sticky <= 1'b0;
      end else if (fault_clr) begin
         fault_cnt        <= (accept & fault_now) ? {{(FAULT_CNT_WIDTH-1){1'b0}}, 1'b1} : '0;
         ecc_fault_sticky <= accept & fault_now;
      end else if (accept & fault_now) begin
         ecc_fault_sticky <= 1'b1;
         if (fault_cnt != '1) fault_cnt <= fault_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ecc_145_enc_fault_detc.sv
// Directed bench for the 145-bit SECDED encoder with self-check and injector.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Expected parity comes from hand constants and a syndrome-style reference.

module tb_ecc_145_enc_fault_detc;

   logic         clk = 1'b0;
   logic         rst;
   logic         en, bypass, in_valid, in_ready, out_valid, out_ready;
   logic [144:0] data_in, data_out;
   logic [8:0]   parity_out;
   logic         ecc_fault, ecc_fault_sticky, fault_clr, chk_inj, inj_req, inj_dbl;
   logic [7:0]   fault_cnt, inj_pos;
   int           errors = 0;
   int           checks = 0;

   always #5 clk = ~clk;

   ecc_145_enc_fault_detc dut (
      .clk(clk), .rst(rst), .ecc_fault_detc_en(en), .bypass(bypass),
      .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
      .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
      .parity_out(parity_out), .ecc_fault(ecc_fault), .ecc_fault_sticky(ecc_fault_sticky),
      .fault_cnt(fault_cnt), .fault_clr(fault_clr), .chk_inj(chk_inj),
      .inj_req(inj_req), .inj_dbl(inj_dbl), .inj_pos(inj_pos)
   );

   // Reference: Hamming bits equal the XOR of the positions of all set data bits.
   function automatic logic [8:0] ref_par(input logic [144:0] d);
      logic [7:0] syn;
      int pos;
      syn = '0;
      pos = 3;
      for (int k = 0; k < 145; k++) begin
         while ((pos & (pos - 1)) == 0) pos++;
         if (d[k]) syn ^= pos[7:0];
         pos++;
      end
      return {(^d) ^ (^syn), syn};
   endfunction

   function automatic logic [144:0] rand_word();
      logic [159:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return t[144:0];
   endfunction

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; bypass = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      data_in = '0; fault_clr = 1'b0; chk_inj = 1'b0; inj_req = 1'b0; inj_dbl = 1'b0; inj_pos = '0;
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
      checks++; if (parity_out !== 9'h000) begin errors++; $display("FAIL reset_parity got=%h exp=000", parity_out); end
      checks++; if (ecc_fault !== 1'b0 || ecc_fault_sticky !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b%b exp=00", ecc_fault, ecc_fault_sticky); end
      checks++; if (fault_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", fault_cnt); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_basic();
      logic [144:0] v [3];
      logic [8:0]   e [3];
      v[0] = 145'd0; v[1] = 145'd1; v[2] = 145'd2;
      e[0] = 9'h000; e[1] = 9'h103; e[2] = 9'h105;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); in_valid = 1'b1; data_in = v[i];
         @(negedge clk); in_valid = 1'b0;
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got=%b exp=1", i, out_valid); end
         checks++; if (parity_out !== e[i]) begin errors++; $display("FAIL basic_parity[%0d] got=%h exp=%h", i, parity_out, e[i]); end
         checks++; if (ecc_fault !== 1'b0) begin errors++; $display("FAIL basic_fault[%0d] got=%b exp=0", i, ecc_fault); end
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [144:0] w [10];
      int wr, rd, cyc;
      for (int i = 0; i < 10; i++) w[i] = rand_word();
      wr = 0; rd = 0; cyc = 0;
      while (rd < 10 && cyc < 100) begin
         @(negedge clk);
         out_ready = (cyc >= 4);
         if (wr < 10) begin in_valid = 1'b1; data_in = w[wr]; end
         else in_valid = 1'b0;
         #1;
         if (cyc >= 1 && cyc <= 3) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", cyc, in_ready); end
            checks++; if (out_valid !== 1'b1 || data_out !== w[0]) begin errors++; $display("FAIL bp_hold[%0d] got=%h exp=%h", cyc, data_out, w[0]); end
         end
         if (out_valid && out_ready) begin
            checks++; if (data_out !== w[rd] || parity_out !== ref_par(w[rd])) begin errors++; $display("FAIL bp_drain[%0d] got=%h/%h exp=%h/%h", rd, data_out, parity_out, w[rd], ref_par(w[rd])); end
            rd++;
         end
         if (in_valid && in_ready) wr++;
         cyc++;
      end
      checks++; if (rd != 10 || wr != 10) begin errors++; $display("FAIL bp_count got=rd%0d/wr%0d exp=10/10", rd, wr); end
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
   endtask

   task automatic test_selfcheck();
      logic [144:0] d;
      chk_inj = 1'b1;
      for (int pass = 0; pass < 2; pass++) begin
         en = (pass == 0);
         for (int i = 0; i < 3; i++) begin
            d = rand_word();
            @(negedge clk); in_valid = 1'b1; data_in = d;
            @(negedge clk); in_valid = 1'b0;
            checks++; if (ecc_fault !== en) begin errors++; $display("FAIL selfchk_fault[%0d,%0d] got=%b exp=%b", pass, i, ecc_fault, en); end
            checks++; if (parity_out !== ref_par(d)) begin errors++; $display("FAIL selfchk_parity[%0d,%0d] got=%h exp=%h", pass, i, parity_out, ref_par(d)); end
         end
         checks++; if (fault_cnt !== 8'd3 || ecc_fault_sticky !== 1'b1) begin errors++; $display("FAIL selfchk_cnt[%0d] got=%0d/%b exp=3/1", pass, fault_cnt, ecc_fault_sticky); end
      end
      // Bypass: zero parity, no fault unless the compare is deliberately upset.
      en = 1'b1; bypass = 1'b1; chk_inj = 1'b0;
      @(negedge clk); in_valid = 1'b1; data_in = rand_word();
      @(negedge clk); in_valid = 1'b0;
      checks++; if (parity_out !== 9'h000 || ecc_fault !== 1'b0) begin errors++; $display("FAIL bypass_clean got=%h/%b exp=000/0", parity_out, ecc_fault); end
      chk_inj = 1'b1;
      @(negedge clk); in_valid = 1'b1; data_in = rand_word();
      @(negedge clk); in_valid = 1'b0;
      checks++; if (ecc_fault !== 1'b1 || fault_cnt !== 8'd4) begin errors++; $display("FAIL bypass_chk got=%b/%0d exp=1/4", ecc_fault, fault_cnt); end
      bypass = 1'b0; chk_inj = 1'b0;
   endtask

   task automatic test_saturation();
      @(negedge clk); fault_clr = 1'b1;
      @(negedge clk); fault_clr = 1'b0;
      checks++; if (fault_cnt !== 8'd0 || ecc_fault_sticky !== 1'b0) begin errors++; $display("FAIL clr got=%0d/%b exp=0/0", fault_cnt, ecc_fault_sticky); end
      chk_inj = 1'b1; en = 1'b1;
      for (int i = 0; i < 260; i++) begin
         @(negedge clk); in_valid = 1'b1; data_in = rand_word();
      end
      @(negedge clk); in_valid = 1'b0;
      checks++; if (fault_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt got=%0d exp=255", fault_cnt); end
      @(negedge clk); fault_clr = 1'b1; in_valid = 1'b1; data_in = rand_word();
      @(negedge clk); fault_clr = 1'b0; in_valid = 1'b0;
      checks++; if (fault_cnt !== 8'd1 || ecc_fault_sticky !== 1'b1) begin errors++; $display("FAIL clr_and_fault got=%0d/%b exp=1/1", fault_cnt, ecc_fault_sticky); end
      chk_inj = 1'b0;
   endtask

   task automatic test_injection();
      logic [144:0] one, d, d2;
      one = 145'd1;
      for (int dbl = 0; dbl < 2; dbl++) begin
         d = rand_word(); d2 = rand_word();
         @(negedge clk); inj_req = 1'b1; inj_dbl = dbl[0]; inj_pos = 8'd144;
         @(negedge clk); inj_req = 1'b0; in_valid = 1'b1; data_in = d;
         @(negedge clk); data_in = d2;
         checks++; if (data_out !== (d ^ (one << 144) ^ (dbl[0] ? one : '0))) begin errors++; $display("FAIL inj_data[%0d] got=%h exp=%h", dbl, data_out, d ^ (one << 144) ^ (dbl[0] ? one : '0)); end
         checks++; if (parity_out !== ref_par(d)) begin errors++; $display("FAIL inj_parity[%0d] got=%h exp=%h", dbl, parity_out, ref_par(d)); end
         @(negedge clk); in_valid = 1'b0;
         checks++; if (data_out !== d2) begin errors++; $display("FAIL inj_after[%0d] got=%h exp=%h", dbl, data_out, d2); end
      end
      // Arming in the same cycle as an acceptance leaves that beat clean; pos 200 wraps to 55.
      d = rand_word(); d2 = rand_word();
      @(negedge clk); inj_req = 1'b1; inj_dbl = 1'b0; inj_pos = 8'd200; in_valid = 1'b1; data_in = d;
      @(negedge clk); inj_req = 1'b0; data_in = d2;
      checks++; if (data_out !== d) begin errors++; $display("FAIL inj_same_cycle got=%h exp=%h", data_out, d); end
      @(negedge clk); in_valid = 1'b0;
      checks++; if (data_out !== (d2 ^ (one << 55))) begin errors++; $display("FAIL inj_wrap got=%h exp=%h", data_out, d2 ^ (one << 55)); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [144:0] d, d2;
      d = rand_word(); d2 = rand_word();
      @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; data_in = d; chk_inj = 1'b1;
      @(negedge clk); in_valid = 1'b0; chk_inj = 1'b0; inj_req = 1'b1; inj_dbl = 1'b1; inj_pos = 8'd10;
      @(negedge clk); inj_req = 1'b0;
      checks++; if (out_valid !== 1'b1 || fault_cnt !== 8'd2) begin errors++; $display("FAIL mid_pre got=%b/%0d exp=1/2", out_valid, fault_cnt); end
      rst = 1'b1; #1;
      checks++; if (out_valid !== 1'b0 || fault_cnt !== 8'd0 || ecc_fault_sticky !== 1'b0) begin errors++; $display("FAIL mid_rst got=%b/%0d/%b exp=0/0/0", out_valid, fault_cnt, ecc_fault_sticky); end
      @(negedge clk); rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; data_in = d2;
      @(negedge clk); in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || data_out !== d2) begin errors++; $display("FAIL mid_clean got=%h exp=%h", data_out, d2); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_selfcheck();
      test_saturation();
      test_injection();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ecc_145_enc_fault_detc.md
# ecc_145_enc_fault_detc

Write-side SECDED encoder for 145-bit FIFO words with built-in encoder self-check and a test-only error injector. Each accepted word is encoded by two identical encoder instances and the two parity results are compared. The word plus the 9-bit parity is then registered into a one-deep valid/ready output stage, ahead of the RAM write port. The decoder on the read side uses the same code mapping, so a stored word decodes cleanly unless an error was injected or a fault occurred.

## Interface
- DATA_WIDTH, 145, data bits per word
- PARITY_WIDTH, 9, check bits: 8 Hamming bits plus 1 overall-parity bit
- FAULT_CNT_WIDTH, 8, width of the saturating fault counter

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- ecc_fault_detc_en  in  1  enables the dual-encoder compare
- bypass  in  1  forces parity to all zeros; encoder compare result is ignored
- in_valid  in  1  input word valid
- in_ready  out  1  input accepted when in_valid & in_ready
- data_in  in  DATA_WIDTH  write data
- out_valid  out  1  output word valid
- out_ready  in  1  downstream ready
- data_out  out  DATA_WIDTH  registered data, with any injected flips applied
- parity_out  out  PARITY_WIDTH  registered parity from encoder instance 0
- ecc_fault  out  1  asserted with the output beat whose encoders mismatched
- ecc_fault_sticky  out  1  set by any faulty accepted beat
- fault_cnt  out  FAULT_CNT_WIDTH  count of faulty accepted beats, saturating
- fault_clr  in  1  clears ecc_fault_sticky and fault_cnt
- chk_inj  in  1  inverts instance-1 parity bit 0 before the compare (self-test)
- inj_req  in  1  one-cycle pulse that arms data error injection
- inj_dbl  in  1  sampled with inj_req: 0 = single-bit flip, 1 = double-bit flip
- inj_pos  in  8  sampled with inj_req: position of the first flipped bit

## Operation
- **Code mapping.**
  - Data bit k maps to codeword position k-th non-power-of-two, starting at 3 (positions 3, 5, 6, 7, 9, …).
  - p[i], for i = 0..7, is the XOR of all data bits whose position has bit i set.
  - p[8] is the XOR of all data bits and p[7:0].
- **Bypass.** When bypass=1, parity from both instances is 0. A fault is impossible unless chk_inj=1 and ecc_fault_detc_en=1.
- **Compare.**
  - mismatch = (par0 ^ {par1[8:1], par1[0]^chk_inj}) != 0.
  - fault = mismatch & ecc_fault_detc_en.
  - parity_out always comes from instance 0; the faulty word is still passed on.
- **Pipeline register.**
  - in_ready = ~out_valid | out_ready.
  - On acceptance, load data, parity and the fault flag.
  - When out_valid & out_ready with no new acceptance, clear out_valid.
- **Injector FSM.**
  - IDLE: inj_req → ARMED. Latch inj_dbl and inj_pos; the latched pos is taken mod DATA_WIDTH.
  - ARMED: the next accepted beat has data bit pos flipped; if dbl, bit (pos+1) mod DATA_WIDTH is also flipped. Then → IDLE.
  - Parity is computed on the unflipped data, so the downstream decoder sees a single-bit or double-bit error.
  - inj_req while ARMED is ignored.
  - inj_req in the same cycle as an acceptance while IDLE only arms; that beat is not corrupted.
- **Fault counter.**
  - Increments on each accepted beat with fault=1.
  - Saturates at all-ones.
  - Sticky is set on the same event.
  - fault_clr clears both. If fault_clr and a fault increment occur in the same cycle, the result is cnt=1, sticky=1.

## Timing
- Latency is 1 cycle from acceptance to out_valid. Full throughput: one beat per cycle when out_ready=1.
- ecc_fault, data_out and parity_out are stable while out_valid=1 and out_ready=0.
- ecc_fault is meaningful only when out_valid=1. It is driven 0 whenever out_valid=0.
- Reset values:
  - out_valid=0, data_out=0, parity_out=0, ecc_fault=0
  - ecc_fault_sticky=0, fault_cnt=0
  - FSM=IDLE
  - in_ready=1 after reset
- Reset asserted mid-operation:
  - The held output word is dropped.
  - An armed injection is cancelled.
  - Counters are cleared.
- Control inputs are sampled on the acceptance cycle: ecc_fault_detc_en, bypass, chk_inj.

## Test plan
- **Basic encode.** Reset, then send data=0, then data with only bit 0 set, then data with only bit 1 set. Expect parity_out 0x000, 0x103, 0x105, each one cycle after acceptance, with ecc_fault=0.
- **Backpressure.** Hold out_ready=0 for 3 cycles with in_valid=1. Expect in_ready=0 after the first beat, the output held stable, then a back-to-back drain with no word loss or duplication across 10 random words.
- **Self-check fault.**
  - chk_inj=1, en=1 on 3 beats: expect ecc_fault=1 on each beat, fault_cnt=3, sticky=1.
  - Repeat with en=0: ecc_fault=0, fault_cnt unchanged.
- **Counter saturation and clear.**
  - 260 faulty beats with FAULT_CNT_WIDTH=8: fault_cnt=255.
  - fault_clr together with a faulty beat: fault_cnt=1, sticky=1.
- **Injection.**
  - inj_req with inj_dbl=0, inj_pos=144: the next beat has data bit 144 flipped while parity_out matches the clean data.
  - inj_dbl=1, inj_pos=144: bits 144 and 0 are flipped.
  - The beat after each injection is clean.
- **Reset mid-operation.** Arm injection, hold a word with out_ready=0, then assert rst. Expect out_valid=0, fault_cnt=0, and the next accepted word uncorrupted.
